// File: rtl/serial_add_ctrl.sv
// Bit-serial add/subtract sequencer driving one external full-adder slice.
// Operands are consumed LSB first, one bit per RUN cycle. The result is held
// in DONE until the sink takes it.
module serial_add_ctrl #(
    parameter int unsigned WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    // operand source
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_a,
    input  logic [WIDTH-1:0] in_b,
    input  logic             in_cin,
    input  logic             in_sub,
    // external 1-bit slice
    output logic             fa_a,
    output logic             fa_b,
    output logic             fa_cin,
    input  logic             fa_sum,
    input  logic             fa_cout,
    // result sink
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_sum,
    output logic             out_cout,
    output logic             busy
);

    localparam int unsigned CntW = $clog2(WIDTH + 1);

    typedef enum logic [1:0] {
        StIdle,
        StRun,
        StDone
    } state_e;

    state_e            state_q, state_d;
    logic [WIDTH-1:0]  a_sh_q, a_sh_d;
    logic [WIDTH-1:0]  b_sh_q, b_sh_d;
    logic [WIDTH-1:0]  sum_sh_q, sum_sh_d;
    logic              carry_q, carry_d;
    logic [CntW-1:0]   cnt_q, cnt_d;
    logic [WIDTH-1:0]  out_sum_q, out_sum_d;
    logic              out_cout_q, out_cout_d;
    logic [WIDTH-1:0]  sum_next;

    // Sum register after this cycle's shift: slice sum enters at the MSB.
    always_comb begin
        sum_next            = sum_sh_q >> 1;
        sum_next[WIDTH-1]   = fa_sum;
    end

    // Next-state and datapath update.
    always_comb begin
        state_d    = state_q;
        a_sh_d     = a_sh_q;
        b_sh_d     = b_sh_q;
        sum_sh_d   = sum_sh_q;
        carry_d    = carry_q;
        cnt_d      = cnt_q;
        out_sum_d  = out_sum_q;
        out_cout_d = out_cout_q;
        unique case (state_q)
            StIdle: begin
                if (in_valid) begin
                    a_sh_d  = in_a;
                    // Subtraction is A + ~B + 1.
                    b_sh_d  = in_b ^ {WIDTH{in_sub}};
                    carry_d = in_sub | in_cin;
                    cnt_d   = '0;
                    state_d = StRun;
                end
            end
            StRun: begin
                sum_sh_d = sum_next;
                carry_d  = fa_cout;
                a_sh_d   = a_sh_q >> 1;
                b_sh_d   = b_sh_q >> 1;
                cnt_d    = cnt_q + CntW'(1);
                if (cnt_q == CntW'(WIDTH - 1)) begin
                    out_sum_d  = sum_next;
                    out_cout_d = fa_cout;
                    state_d    = StDone;
                end
            end
            StDone: begin
                if (out_ready) begin
                    state_d = StIdle;
                end
            end
            default: state_d = StIdle;
        endcase
    end

    // State and datapath registers; reset aborts any operation in flight.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= StIdle;
            a_sh_q     <= '0;
            b_sh_q     <= '0;
            sum_sh_q   <= '0;
            carry_q    <= 1'b0;
            cnt_q      <= '0;
            out_sum_q  <= '0;
            out_cout_q <= 1'b0;
        end else begin
            state_q    <= state_d;
            a_sh_q     <= a_sh_d;
            b_sh_q     <= b_sh_d;
            sum_sh_q   <= sum_sh_d;
            carry_q    <= carry_d;
            cnt_q      <= cnt_d;
            out_sum_q  <= out_sum_d;
            out_cout_q <= out_cout_d;
        end
    end

    // Handshake and slice outputs decoded from state; slice inputs are zero off RUN.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        busy      = 1'b1;
        fa_a      = 1'b0;
        fa_b      = 1'b0;
        fa_cin    = 1'b0;
        unique case (state_q)
            StIdle: begin
                in_ready = 1'b1;
                busy     = 1'b0;
            end
            StRun: begin
                fa_a   = a_sh_q[0];
                fa_b   = b_sh_q[0];
                fa_cin = carry_q;
            end
            StDone: out_valid = 1'b1;
            default: ;
        endcase
    end

    assign out_sum  = out_sum_q;
    assign out_cout = out_cout_q;

endmodule

// File: tb/tb_serial_add_ctrl.sv
// Directed and random checks of serial_add_ctrl with a behavioural full-adder slice.
module tb_serial_add_ctrl;

    logic       clk;
    logic       rst_n;

    // WIDTH=8 instance
    logic       in_valid, in_ready, in_cin, in_sub;
    logic [7:0] in_a, in_b, out_sum;
    logic       fa_a, fa_b, fa_cin, fa_sum, fa_cout;
    logic       out_valid, out_ready, out_cout, busy;

    // WIDTH=1 instance
    logic       w1_in_valid, w1_in_ready, w1_in_cin, w1_in_sub;
    logic [0:0] w1_in_a, w1_in_b, w1_out_sum;
    logic       w1_fa_a, w1_fa_b, w1_fa_cin, w1_fa_sum, w1_fa_cout;
    logic       w1_out_valid, w1_out_ready, w1_out_cout, w1_busy;

    int vectors;
    int miscompares;

    assign fa_sum     = fa_a ^ fa_b ^ fa_cin;
    assign fa_cout    = (fa_a & fa_b) | (fa_a & fa_cin) | (fa_b & fa_cin);
    assign w1_fa_sum  = w1_fa_a ^ w1_fa_b ^ w1_fa_cin;
    assign w1_fa_cout = (w1_fa_a & w1_fa_b) | (w1_fa_a & w1_fa_cin) | (w1_fa_b & w1_fa_cin);

    serial_add_ctrl #(.WIDTH(8)) u_dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_a      (in_a),
        .in_b      (in_b),
        .in_cin    (in_cin),
        .in_sub    (in_sub),
        .fa_a      (fa_a),
        .fa_b      (fa_b),
        .fa_cin    (fa_cin),
        .fa_sum    (fa_sum),
        .fa_cout   (fa_cout),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_sum   (out_sum),
        .out_cout  (out_cout),
        .busy      (busy)
    );

    serial_add_ctrl #(.WIDTH(1)) u_dut_w1 (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (w1_in_valid),
        .in_ready  (w1_in_ready),
        .in_a      (w1_in_a),
        .in_b      (w1_in_b),
        .in_cin    (w1_in_cin),
        .in_sub    (w1_in_sub),
        .fa_a      (w1_fa_a),
        .fa_b      (w1_fa_b),
        .fa_cin    (w1_fa_cin),
        .fa_sum    (w1_fa_sum),
        .fa_cout   (w1_fa_cout),
        .out_valid (w1_out_valid),
        .out_ready (w1_out_ready),
        .out_sum   (w1_out_sum),
        .out_cout  (w1_out_cout),
        .busy      (w1_busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        vectors++;
        if (got !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    // Step to 1 time unit after the next rising edge.
    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // One full transaction from IDLE; returns to IDLE at the end.
    task automatic run_op(input logic [7:0] a, input logic [7:0] b, input logic cin,
                          input logic sub, input int stall, input logic [7:0] exp_sum,
                          input logic exp_cout, input logic full);
        int n;
        logic [7:0] held_sum;
        logic       held_cout;
        check("idle_in_ready", in_ready, 1);
        in_a     = a;
        in_b     = b;
        in_cin   = cin;
        in_sub   = sub;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        // Scramble operand inputs: they must only matter on the accepting edge.
        in_a     = ~a;
        in_b     = ~b;
        in_cin   = ~cin;
        if (full) begin
            check("run_busy", busy, 1);
            check("run_in_ready", in_ready, 0);
            check("run_fa_a", fa_a, a[0]);
            check("run_fa_b", fa_b, b[0] ^ sub);
            check("run_fa_cin", fa_cin, sub ? 1'b1 : cin);
        end
        n = 0;
        while (!out_valid && n < 40) begin
            tick();
            n++;
        end
        if (full) check("latency", n, 8);
        else      check("done_reached", out_valid, 1);
        check("out_sum", out_sum, exp_sum);
        check("out_cout", out_cout, exp_cout);
        if (full) begin
            check("done_fa_a", fa_a, 0);
            check("done_fa_cin", fa_cin, 0);
        end
        held_sum  = out_sum;
        held_cout = out_cout;
        out_ready = 1'b0;
        for (int i = 0; i < stall; i++) begin
            in_valid = 1'b1;
            in_a     = 8'hA5;
            in_b     = 8'h5A;
            tick();
            if (full) begin
                check("stall_valid", out_valid, 1);
                check("stall_sum", out_sum, exp_sum);
                check("stall_cout", out_cout, exp_cout);
                check("stall_in_ready", in_ready, 0);
            end
        end
        in_valid  = 1'b0;
        out_ready = 1'b1;
        tick();
        out_ready = 1'b0;
        check("hs_out_valid", out_valid, 0);
        if (full) begin
            check("hs_in_ready", in_ready, 1);
            check("kept_sum", out_sum, held_sum);
            check("kept_cout", out_cout, held_cout);
        end
    endtask

    initial begin
        logic [8:0] ref_res;
        logic [7:0] ra, rb;
        logic       rc, rs;
        vectors      = 0;
        miscompares  = 0;
        in_valid     = 1'b0;
        in_a         = '0;
        in_b         = '0;
        in_cin       = 1'b0;
        in_sub       = 1'b0;
        out_ready    = 1'b0;
        w1_in_valid  = 1'b0;
        w1_in_a      = '0;
        w1_in_b      = '0;
        w1_in_cin    = 1'b0;
        w1_in_sub    = 1'b0;
        w1_out_ready = 1'b0;
        rst_n        = 1'b0;
        #1;
        check("rst_in_ready", in_ready, 1);
        check("rst_out_valid", out_valid, 0);
        check("rst_out_sum", out_sum, 0);
        check("rst_out_cout", out_cout, 0);
        check("rst_busy", busy, 0);
        check("rst_fa", {fa_a, fa_b, fa_cin}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();

        // Additions, including carry out of the top bit.
        run_op(8'h3C, 8'h5A, 1'b0, 1'b0, 0, 8'h96, 1'b0, 1'b1);
        run_op(8'hFF, 8'h01, 1'b0, 1'b0, 0, 8'h00, 1'b1, 1'b1);
        run_op(8'hFF, 8'h00, 1'b1, 1'b0, 0, 8'h00, 1'b1, 1'b1);
        // Subtractions; carry-in must be ignored.
        run_op(8'h10, 8'h01, 1'b0, 1'b1, 0, 8'h0F, 1'b1, 1'b1);
        run_op(8'h01, 8'h02, 1'b1, 1'b1, 0, 8'hFF, 1'b0, 1'b1);
        // Back-pressure in DONE, then an immediate next transaction.
        run_op(8'h12, 8'h34, 1'b1, 1'b0, 5, 8'h47, 1'b0, 1'b1);
        run_op(8'h80, 8'h80, 1'b0, 1'b0, 0, 8'h00, 1'b1, 1'b1);

        // Reset three cycles into RUN aborts the operation.
        run_op(8'h55, 8'h22, 1'b0, 1'b0, 0, 8'h77, 1'b0, 1'b1);
        in_a     = 8'h0F;
        in_b     = 8'h0F;
        in_cin   = 1'b0;
        in_sub   = 1'b0;
        in_valid = 1'b1;
        tick();
        in_valid = 1'b0;
        tick();
        tick();
        tick();
        check("pre_abort_busy", busy, 1);
        rst_n = 1'b0;
        #1;
        check("abort_busy", busy, 0);
        check("abort_in_ready", in_ready, 1);
        check("abort_out_sum", out_sum, 0);
        check("abort_out_cout", out_cout, 0);
        check("abort_fa", {fa_a, fa_b, fa_cin}, 0);
        tick();
        tick();
        rst_n = 1'b1;
        tick();
        check("post_rst_in_ready", in_ready, 1);
        for (int i = 0; i < 10; i++) begin
            tick();
            if (out_valid) check("post_rst_no_result", out_valid, 0);
        end
        check("post_rst_idle", out_valid, 0);
        run_op(8'h01, 8'h01, 1'b0, 1'b0, 0, 8'h02, 1'b0, 1'b1);

        // WIDTH=1: 1+1+1 -> sum 1, carry 1 after one RUN cycle.
        w1_in_a     = 1'b1;
        w1_in_b     = 1'b1;
        w1_in_cin   = 1'b1;
        w1_in_valid = 1'b1;
        tick();
        w1_in_valid = 1'b0;
        check("w1_run_busy", w1_busy, 1);
        check("w1_run_valid", w1_out_valid, 0);
        tick();
        check("w1_done_valid", w1_out_valid, 1);
        check("w1_out_sum", w1_out_sum, 1);
        check("w1_out_cout", w1_out_cout, 1);
        w1_out_ready = 1'b1;
        tick();
        w1_out_ready = 1'b0;
        check("w1_back_idle", w1_in_ready, 1);

        // Random operations against a 9-bit arithmetic reference.
        for (int i = 0; i < 500; i++) begin
            ra = 8'($urandom);
            rb = 8'($urandom);
            rc = 1'($urandom);
            rs = 1'($urandom);
            if (rs) ref_res = {1'b0, ra} + {1'b0, ~rb} + 9'd1;
            else    ref_res = {1'b0, ra} + {1'b0, rb} + {8'd0, rc};
            run_op(ra, rb, rc, rs, int'($urandom_range(0, 3)), ref_res[7:0], ref_res[8], 1'b0);
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
